// File: rtl/clken_gen_pkg.sv
// Shared types and helpers for the clken_gen clock-enable generator.
// Optional square-wave outputs are enabled by defining CLKEN_GEN_SQ_EN.
package clken_gen_pkg;

   typedef enum logic {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } state_t;

   // Width of a channel index; never narrower than one bit.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clken_gen_ch.sv
// One clock-enable channel: phase accumulator, increment register, tick pulse
// and (when CLKEN_GEN_SQ_EN is defined) a toggling square-wave output.
module clken_gen_ch #(
   parameter int               ACC_W       = 32,
   parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             run,
   input  logic             en,
   input  logic             load,
   input  logic [ACC_W-1:0] load_inc,
   output logic             tick,
   output logic             sq_out
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W:0]   sum;

   // The carry out of the accumulator is the tick; it is registered below.
   assign sum = {1'b0, acc} + {1'b0, inc};

   always_ff @(posedge refclk) begin
      if (rst) begin
         acc  <= '0;
         inc  <= DEFAULT_INC;
         tick <= 1'b0;
      end else begin
         if (load) begin
            inc <= load_inc;
         end
         if (run && en) begin
            acc  <= sum[ACC_W-1:0];
            tick <= sum[ACC_W];
         end else begin
            acc  <= '0;
            tick <= 1'b0;
         end
      end
   end

`ifdef CLKEN_GEN_SQ_EN
   logic sq_q;

   // Toggles on every cycle the tick is high, giving half the tick rate.
   always_ff @(posedge refclk) begin
      if (rst || load || !en) begin
         sq_q <= 1'b0;
      end else begin
         sq_q <= sq_q ^ tick;
      end
   end

   assign sq_out = sq_q;
`else
   assign sq_out = 1'b0;
`endif

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator: settle/run FSM, settle
// counter and config decode. Define CLKEN_GEN_SQ_EN to build square-wave outputs.
module clken_gen
   import clken_gen_pkg::*;
#(
   parameter int               NUM_CH      = 2,
   parameter int               ACC_W       = 32,
   parameter int               LOCK_CYCLES = 1024,
   parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
   input  logic                        refclk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           ch_en,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
   input  logic [ACC_W-1:0]            cfg_inc,
   output logic [NUM_CH-1:0]           tick,
   output logic [NUM_CH-1:0]           sq_out,
   output logic                        locked
);

   localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   state_t            state;
   logic [CNT_W-1:0]  settle_cnt;
   logic              cfg_hs;
   logic              cfg_hit;
   logic              ch_run;
   logic [NUM_CH-1:0] ch_load;

   // Config transfers on a cycle with cfg_valid && cfg_ready; the requester
   // holds cfg_ch/cfg_inc stable until then. Out-of-range channels are
   // accepted and dropped without disturbing the running channels.
   assign cfg_hs  = cfg_valid && cfg_ready;
   assign cfg_hit = cfg_hs && (32'(cfg_ch) < 32'(NUM_CH));
   assign ch_run  = (state == RUN) && !cfg_hit;

   always_comb begin
      ch_load = '0;
      if (cfg_hit) begin
         ch_load[cfg_ch] = 1'b1;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state      <= SETTLE;
         settle_cnt <= '0;
         locked     <= 1'b0;
         cfg_ready  <= 1'b0;
      end else begin
         case (state)
            SETTLE: begin
               if (settle_cnt == CNT_LAST) begin
                  state      <= RUN;
                  settle_cnt <= '0;
                  locked     <= 1'b1;
                  cfg_ready  <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (cfg_hit) begin
                  state      <= SETTLE;
                  settle_cnt <= '0;
                  locked     <= 1'b0;
                  cfg_ready  <= 1'b0;
               end
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clken_gen_ch #(
         .ACC_W       (ACC_W),
         .DEFAULT_INC (DEFAULT_INC)
      ) u_ch (
         .refclk   (refclk),
         .rst      (rst),
         .run      (ch_run),
         .en       (ch_en[i]),
         .load     (ch_load[i]),
         .load_inc (cfg_inc),
         .tick     (tick[i]),
         .sq_out   (sq_out[i])
      );
   end

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen; a second 3-channel instance exercises the
// out-of-range config channel, which a 2-channel cfg_ch cannot encode.
module tb_clken_gen;

   localparam int W = 9;
`ifdef CLKEN_GEN_SQ_EN
   localparam logic SQ_EN = 1'b1;
`else
   localparam logic SQ_EN = 1'b0;
`endif
   localparam logic [W-1:0] FULL   = '1;
   localparam logic [W-1:0] NO_SQ1 = ~9'b000000010;

   logic       refclk = 1'b0;
   logic       rst;
   logic [1:0] ch_en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [0:0] cfg_ch;
   logic [7:0] cfg_inc;
   logic [1:0] tick;
   logic [1:0] sq_out;
   logic       locked;

   logic [2:0] ch_en3;
   logic       cfg_valid3;
   logic       cfg_ready3;
   logic [1:0] cfg_ch3;
   logic [7:0] cfg_inc3;
   logic [2:0] tick3;
   logic [2:0] sq_out3;
   logic       locked3;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mask_q[$];
   string        tag_q[$];
   int           checks = 0;
   int           errors = 0;
   int           k3 = 0;

   // ---------------- clock / reset ----------------
   always #5 refclk = ~refclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   clken_gen #(
      .NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(4), .DEFAULT_INC(8'd0)
   ) u_dut (
      .refclk(refclk), .rst(rst), .ch_en(ch_en), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
      .tick(tick), .sq_out(sq_out), .locked(locked)
   );

   clken_gen #(
      .NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(4), .DEFAULT_INC(8'd0)
   ) u_dut3 (
      .refclk(refclk), .rst(rst), .ch_en(ch_en3), .cfg_valid(cfg_valid3),
      .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3), .cfg_inc(cfg_inc3),
      .tick(tick3), .sq_out(sq_out3), .locked(locked3)
   );

   // ---------------- driver tasks ----------------
   function automatic logic [W-1:0] mk(input logic l, input logic r,
                                       input logic [1:0] t, input logic [1:0] s,
                                       input logic l3, input logic r3, input logic t3);
      return {l3, r3, t3, l, r, t, s & {2{SQ_EN}}};
   endfunction

   task automatic cyc(input logic [W-1:0] e, input logic [W-1:0] m, input string tag);
      @(posedge refclk);
      #1;
      exp_q.push_back(e);
      mask_q.push_back(m);
      tag_q.push_back(tag);
   endtask

   // Cycle in which the 3-channel instance is running ch0 at inc=128.
   task automatic run_cyc(input logic l, input logic r, input logic [1:0] t,
                          input logic [1:0] s, input logic [W-1:0] m, input string tag);
      k3++;
      cyc(mk(l, r, t, s, 1'b1, 1'b1, (k3 % 2 == 0)), m, tag);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge refclk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e, m, act;
         string        tg;
         e   = exp_q.pop_front();
         m   = mask_q.pop_front();
         tg  = tag_q.pop_front();
         act = {locked3, cfg_ready3, tick3[0], locked, cfg_ready, tick, sq_out};
         checks++;
         if (((act ^ e) & m) != '0) begin
            errors++;
            $display("FAIL %s: got %b expected %b (mask %b) at %0t", tg, act, e, m, $time);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; ch_en = 2'b11; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
      ch_en3 = 3'b001; cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_inc3 = '0;

      // Reset and first lock: locked on the 4th edge, no ticks with inc=0.
      cyc(mk(0, 0, 2'b00, 2'b00, 0, 0, 0), FULL, "reset");
      cyc(mk(0, 0, 2'b00, 2'b00, 0, 0, 0), FULL, "reset_hold");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(mk(0, 0, 2'b00, 2'b00, 0, 0, 0), FULL, "settle");
      cyc(mk(1, 1, 2'b00, 2'b00, 1, 1, 0), FULL, "lock");
      for (int i = 0; i < 3; i++) cyc(mk(1, 1, 2'b00, 2'b00, 1, 1, 0), FULL, "idle_inc0");

      // ch0 inc=128 on both instances.
      cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd128;
      cfg_valid3 = 1'b1; cfg_ch3 = 2'd0; cfg_inc3 = 8'd128;
      cyc(mk(0, 0, 2'b00, 2'b00, 0, 0, 0), FULL, "cfg0_accept");
      cfg_valid = 1'b0; cfg_valid3 = 1'b0;
      for (int i = 0; i < 3; i++) cyc(mk(0, 0, 2'b00, 2'b00, 0, 0, 0), FULL, "cfg0_settle");
      cyc(mk(1, 1, 2'b00, 2'b00, 1, 1, 0), FULL, "cfg0_lock");
      for (int k = 1; k <= 8; k++)
         run_cyc(1, 1, {1'b0, k % 2 == 0}, {1'b0, ((k - 1) >> 1) % 2 == 1}, FULL, "ch0_inc128");

      // ch1 inc=64.
      cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'd64;
      run_cyc(0, 0, 2'b00, 2'b00, FULL, "cfg1_accept");
      cfg_valid = 1'b0;
      for (int i = 0; i < 3; i++) run_cyc(0, 0, 2'b00, 2'b00, FULL, "cfg1_settle");
      run_cyc(1, 1, 2'b00, 2'b00, FULL, "cfg1_lock");
      for (int m = 1; m <= 31; m++) begin
         logic t0, s0, t1, s1;
         int   n;
         if (m == 9)  ch_en = 2'b01;
         if (m == 19) ch_en = 2'b11;
         // Out-of-range config on the 3-channel instance: accepted, ignored.
         if (m == 27) begin cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_inc3 = 8'd5; end
         if (m == 28) cfg_valid3 = 1'b0;
         t0 = (m % 2 == 0);
         s0 = (((m - 1) >> 1) % 2 == 1);
         n  = (m <= 8) ? m : m - 18;
         if (m >= 9 && m <= 18) begin
            t1 = 1'b0; s1 = 1'b0;
         end else begin
            t1 = (n % 4 == 0);
            s1 = (((n - 1) >> 2) % 2 == 1);
         end
         run_cyc(1, 1, {t1, t0}, {s1, s0}, FULL,
                 (m < 9) ? "ch1_inc64" : (m < 19) ? "ch1_disabled" :
                 (m < 27) ? "ch1_reenable" : "cfg_out_of_range");
      end

      // ch0 inc=255: ticks on every cycle except one in each 256.
      cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd255;
      run_cyc(0, 0, 2'b00, 2'b00, NO_SQ1, "cfg255_accept");
      cfg_valid = 1'b0;
      for (int i = 0; i < 3; i++) run_cyc(0, 0, 2'b00, 2'b00, NO_SQ1, "cfg255_settle");
      run_cyc(1, 1, 2'b00, 2'b00, NO_SQ1, "cfg255_lock");
      for (int p = 1; p <= 257; p++)
         run_cyc(1, 1, {p % 4 == 0, p % 256 != 1}, {1'b0, (p >= 2) && ((p - 2) % 2 == 1)},
                 NO_SQ1, "ch0_inc255");

      // Reset pulse with a simultaneous config request.
      rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd77;
      cyc(mk(0, 0, 2'b00, 2'b00, 0, 0, 0), FULL, "rst_mid_run");
      rst = 1'b0; cfg_valid = 1'b0;
      for (int i = 0; i < 3; i++) cyc(mk(0, 0, 2'b00, 2'b00, 0, 0, 0), FULL, "rst_settle");
      cyc(mk(1, 1, 2'b00, 2'b00, 1, 1, 0), FULL, "rst_relock");
      for (int i = 0; i < 8; i++) cyc(mk(1, 1, 2'b00, 2'b00, 1, 1, 0), FULL, "post_rst_inc0");

      repeat (2) @(posedge refclk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end

      // ---------------- final report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clken_gen.md
CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - NUM_CH, 2, number of output channels (>=1).
  - ACC_W, 32, phase-accumulator width in bits (>=4).
  - LOCK_CYCLES, 1024, settle cycles before locked asserts (>=1).
  - DEFAULT_INC, 0, per-channel increment loaded at reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - refclk, in, 1, sole clock, rising edge.
  - rst, in, 1, reset: synchronous, active-high.
  - ch_en, in, NUM_CH, per-channel run enable.
  - cfg_valid, in, 1, config request.
  - cfg_ready, out, 1, config accept.
  - cfg_ch, in, max(1,$clog2(NUM_CH)), target channel.
  - cfg_inc, in, ACC_W, new increment.
  - tick, out, NUM_CH, one-cycle enable pulse per channel.
  - sq_out, out, NUM_CH, square wave per channel.
  - locked, out, 1, outputs valid.

Function
REQ-003 The block SHALL have two states: SETTLE and RUN.
REQ-004 In SETTLE the block SHALL:
  - hold all accumulators at 0, with tick=0, locked=0 and cfg_ready=0;
  - increment the settle counter each cycle;
  - enter RUN when the counter reaches LOCK_CYCLES-1.
REQ-005 Timing: locked SHALL rise on the LOCK_CYCLES-th rising edge after entering SETTLE.
REQ-006 In RUN: locked=1 and cfg_ready=1.
REQ-007 Per enabled channel, each RUN cycle: sum = acc + inc (ACC_W+1 bits); acc <= sum[ACC_W-1:0]; tick <= sum[ACC_W].
REQ-008 Tick timing:
  - tick SHALL be registered, one cycle wide, asserted the cycle after the carry;
  - average tick rate SHALL be f_refclk*inc/2^ACC_W;
  - inc=0 SHALL never tick.
REQ-009 Channel disable: ch_en[i]=0 SHALL hold acc[i] at 0 and force tick[i]=0 and sq_out[i]=0 from the next edge.
REQ-010 Channel re-enable: the channel SHALL resume from acc=0.
REQ-011 A config handshake (cfg_valid&&cfg_ready) with cfg_ch<NUM_CH SHALL:
  - load inc[cfg_ch]=cfg_inc;
  - zero that channel's acc and sq_out;
  - clear the settle counter and return to SETTLE;
  - drop locked on the next edge.
REQ-012 A config handshake with cfg_ch>=NUM_CH SHALL be accepted and ignored: no state change, locked stays 1.
REQ-013 cfg_valid while cfg_ready=0 SHALL be ignored; the requester SHALL hold its request until accepted.
REQ-014 Accepted config and ch_en[cfg_ch]=0 in the same cycle: the inc update SHALL still be applied.

Reset
REQ-015 With rst=1 at a rising edge, the next state SHALL be:
  - state=SETTLE and settle counter=0;
  - every acc=0 and every inc=DEFAULT_INC;
  - tick=0, sq_out=0, locked=0, cfg_ready=0.
REQ-016 Reset asserted mid-operation SHALL override any simultaneous config handshake.

Configuration
REQ-017 Macro CLKEN_GEN_SQ_EN defined: sq_out[i] SHALL toggle on every cycle where tick[i]=1. This gives a square wave at half the tick rate; duty is 50% when 2^ACC_W/inc is an integer.
REQ-018 Macro CLKEN_GEN_SQ_EN undefined: sq_out SHALL be tied to 0 and no toggle flops SHALL be built.

Structure
REQ-019 Package clken_gen_pkg SHALL hold the state enum (SETTLE, RUN) and a channel-index-width function.
REQ-020 Sub-module clken_gen_ch SHALL implement one channel: accumulator, increment register, tick and sq_out. It SHALL be instantiated NUM_CH times in a generate loop.
REQ-021 The top level SHALL contain only the FSM, the settle counter and config decode.

Verification
Bench configuration: NUM_CH=2, ACC_W=8, LOCK_CYCLES=4, DEFAULT_INC=0, CLKEN_GEN_SQ_EN defined.
REQ-022 Release rst -> locked=1 at the 4th edge; tick=0 throughout.
REQ-023 Config ch0 inc=128 -> cfg_ready low for 4 cycles, then locked=1; tick[0] every 2nd cycle; sq_out[0] period 4 cycles.
REQ-024 ch1 inc=64, then ch_en[1]=0 for 10 cycles -> tick[1] period 4; no ticks while disabled; first tick 4 cycles after re-enable.
REQ-025 cfg_ch=3 handshake -> accepted; locked stays 1; tick[0] cadence unchanged.
REQ-026 ch0 inc=255 -> 255 ticks in any 256-cycle window.
REQ-027 rst pulse mid-RUN with cfg_valid=1 -> all outputs 0 next edge; inc back to 0; relock after 4 cycles.
